// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, op type and response FSM state encoding
package alu_pkg;
  typedef logic [3:0] op_t;
  localparam op_t OP_ADD = 4'b0000;
  localparam op_t OP_SUB = 4'b0001;
  localparam op_t OP_AND = 4'b0010;
  localparam op_t OP_OR  = 4'b0011;
  localparam op_t OP_XOR = 4'b0100;
  localparam op_t OP_SLL = 4'b0101;
  localparam op_t OP_SRL = 4'b0110;
  localparam op_t OP_SRA = 4'b0111;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/alu_64bit.sv
// alu_64bit: combinational 64-bit ALU, illegal op codes yield zero
module alu_64bit
  import alu_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  op_t         alu_ctrl,
  output logic [63:0] result,
  output logic        zero
);
  logic [5:0] sh;
  logic [63:0] sra;
  assign sh = b[5:0];
  assign sra = $unsigned($signed(a) >>> sh);
  assign result = alu_ctrl == OP_ADD ? a + b :
                  alu_ctrl == OP_SUB ? a - b :
                  alu_ctrl == OP_AND ? a & b :
                  alu_ctrl == OP_OR  ? a | b :
                  alu_ctrl == OP_XOR ? a ^ b :
                  alu_ctrl == OP_SLL ? a << sh :
                  alu_ctrl == OP_SRL ? a >> sh :
                  alu_ctrl == OP_SRA ? sra : '0;
  assign zero = result == '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU with a registered response slot
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_op,
  input  logic [64*NUM_REQ-1:0] req_a,
  input  logic [64*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [63:0]           rsp_result,
  output logic                  rsp_zero,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err
);
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IDW-1:0] last);
    logic [IDW:0] r;
    int j;
    r = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % NUM_REQ;
      if (v[j]) r = {1'b1, IDW'(j)};
    end
    return r;
  endfunction
  state_t state;
  logic [IDW-1:0] last_grant, gid;
  logic [IDW:0] pick;
  logic can_accept, accept, alu_zero;
  op_t op;
  logic [63:0] op_a, op_b, alu_res;
  assign pick = rr_pick(req_valid, last_grant);
  assign gid = pick[IDW-1:0];
  assign can_accept = rst_n && (state == EMPTY || rsp_ready);
  assign req_ready = (can_accept && pick[IDW]) ? NUM_REQ'(1) << gid : '0;
  assign accept = |req_ready;
  assign op = req_op[gid*4 +: 4];
  assign op_a = req_a[gid*64 +: 64];
  assign op_b = req_b[gid*64 +: 64];
  assign rsp_valid = state == FULL;
  alu_64bit u_alu (
    .a(op_a),
    .b(op_b),
    .alu_ctrl(op),
    .result(alu_res),
    .zero(alu_zero)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      rsp_id <= '0;
      rsp_err <= 1'b0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else if (accept) begin
      state <= FULL;
      rsp_result <= alu_res;
      rsp_zero <= alu_zero;
      rsp_id <= gid;
      rsp_err <= op > OP_SRA;
      last_grant <= gid;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the ALU (legal 2..4).
REQ-002 Parameter IDW, default $clog2(NUM_REQ), requester-ID width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-007 req_op  input  4*NUM_REQ  per-requester ALU op code, requester i at bits [4i+3:4i].
REQ-008 req_a  input  64*NUM_REQ  per-requester operand A, requester i at bits [64i+63:64i].
REQ-009 req_b  input  64*NUM_REQ  per-requester operand B, same packing.
REQ-010 rsp_valid  output  1  response register holds a result.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_result  output  64  registered ALU result.
REQ-013 rsp_zero  output  1  registered zero flag (rsp_result == 0).
REQ-014 rsp_id  output  IDW  index of requester that issued the response.
REQ-015 rsp_err  output  1  op code was not a legal encoding.

Function
REQ-016 Op encodings SHALL be: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111; all others illegal.
REQ-017 Shifts SHALL use b[5:0] only; SRA sign-extends a[63]; ADD/SUB wrap modulo 2^64, no carry output.
REQ-018 Illegal op SHALL yield rsp_result = 0, rsp_zero = 1, rsp_err = 1; legal ops yield rsp_err = 0.
REQ-019 FSM SHALL have two states: EMPTY (no response held) and FULL (response held, rsp_valid = 1).
REQ-020 A transfer on port i occurs when req_valid[i] && req_ready[i]; a response transfer when rsp_valid && rsp_ready.
REQ-021 req_ready SHALL be nonzero only when state is EMPTY, or state is FULL and rsp_ready = 1 (drain-and-refill same cycle).
REQ-022 Grant SHALL be round-robin: search starts at index (last_grant+1) mod NUM_REQ; first valid requester wins.
REQ-023 req_ready SHALL depend combinationally on req_valid and rsp_ready; at most one bit set; never set for an invalid requester.
REQ-024 last_grant SHALL update only on an accepted request; unchanged when nothing is granted.
REQ-025 Latency: accepted op in cycle N SHALL appear on rsp_* with rsp_valid = 1 in cycle N+1.
REQ-026 Transitions: EMPTY->FULL on grant; FULL->EMPTY on response transfer with no grant; FULL->FULL on transfer with grant (new data) or no transfer (data held).
REQ-027 While FULL and rsp_ready = 0, rsp_result, rsp_zero, rsp_id, rsp_err SHALL hold stable.
REQ-028 A requester deasserting req_valid before grant SHALL be dropped without effect; pointer unchanged.
REQ-029 Sustained throughput SHALL be one op per cycle when rsp_ready is held high.

Reset
REQ-030 On clk edge with rst_n = 0: state EMPTY, rsp_valid = 0, rsp_result = 0, rsp_zero = 0, rsp_id = 0, rsp_err = 0, last_grant = NUM_REQ-1 (so requester 0 has first priority).
REQ-031 While rst_n = 0, req_ready SHALL be all-zero; an op presented during reset SHALL NOT be accepted.
REQ-032 Reset asserted while FULL SHALL discard the held response with no rsp transfer.

Structure
REQ-033 Op-code localparams (REQ-016), the 4-bit op type and the FSM state enum SHALL live in a shared package alu_pkg.
REQ-034 The datapath SHALL be one instance of alu_64bit (ports a, b, alu_ctrl, result, zero) fed by the granted requester's mux; the arbiter registers its outputs.
REQ-035 The round-robin grant SHALL be a function or block inside alu_arbiter; no further sub-modules.

Verification
REQ-036 Single op: req0 ADD a=5, b=7, rsp_ready=1 -> next cycle rsp_valid=1, result=12, zero=0, id=0, err=0.
REQ-037 Contention: req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-038 Backpressure: rsp_ready=0 after SUB a=9, b=9 -> result=0, zero=1 held stable over 5 cycles, req_ready=0; raise rsp_ready -> drain and new grant same cycle.
REQ-039 Shifts/wrap: SRA a=0x8000_0000_0000_0000, b=0x43 -> 0xF000_0000_0000_0000; ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> 0, zero=1.
REQ-040 Illegal op 1111 on req1 -> result=0, zero=1, err=1, id=1; next legal op clears err.
REQ-041 Reset while FULL with rsp_ready=0 -> after one reset edge rsp_valid=0, first post-reset grant goes to requester 0.
